// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// The optional RAM_ARB_STATS_EN build adds grant/conflict statistics counters.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int HOLD_MAX_MIN = 1;
    localparam int HOLD_MAX_MAX = 15;
    localparam int CNT_W        = 4;

    function automatic bit hold_max_ok(input int h);
        return (h >= HOLD_MAX_MIN) && (h <= HOLD_MAX_MAX);
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational hold-limited round-robin decision: grant, next owner and hold count.
module ram_arb_rr_pick
    import ram_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  arb_state_t         state,
    input  logic               req0,
    input  logic               req1,
    input  logic [CNT_W-1:0]   cnt,
    input  logic               last_owner,
    output logic               gnt0,
    output logic               gnt1,
    output arb_state_t         next_state,
    output logic [CNT_W-1:0]   next_cnt,
    output logic               next_last
);

    // An out-of-range HOLD_MAX falls back to the largest legal run length.
    localparam logic [CNT_W-1:0] HOLD_LIM =
        CNT_W'(hold_max_ok(HOLD_MAX) ? HOLD_MAX : HOLD_MAX_MAX);

    logic own_id_s;
    logic own_req_s;
    logic oth_req_s;
    logic pick_s;
    logic pick_id_s;

    // Next-owner decision for the current cycle.
    always_comb begin
        pick_s     = 1'b0;
        pick_id_s  = M0;
        next_state = state;
        next_cnt   = cnt;
        next_last  = last_owner;
        own_id_s   = (state == OWN1) ? M1 : M0;
        own_req_s  = own_id_s ? req1 : req0;
        oth_req_s  = own_id_s ? req0 : req1;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    pick_s    = 1'b1;
                    pick_id_s = (last_owner == M1) ? M0 : M1;
                    next_cnt  = CNT_W'(1);
                end else if (req0 || req1) begin
                    pick_s    = 1'b1;
                    pick_id_s = req1 ? M1 : M0;
                    next_cnt  = '0;
                end else begin
                    next_cnt  = '0;
                end
                if (pick_s) begin
                    next_state = pick_id_s ? OWN1 : OWN0;
                end else begin
                    next_state = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (own_req_s && !(oth_req_s && (cnt == HOLD_LIM))) begin
                    pick_s    = 1'b1;
                    pick_id_s = own_id_s;
                    if (!oth_req_s) begin
                        next_cnt = '0;
                    end else if (cnt >= HOLD_LIM) begin
                        next_cnt = HOLD_LIM;
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end else if (oth_req_s) begin
                    pick_s     = 1'b1;
                    pick_id_s  = ~own_id_s;
                    next_state = own_id_s ? OWN0 : OWN1;
                    next_cnt   = CNT_W'(1);
                end else begin
                    next_state = IDLE;
                    next_last  = own_id_s;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
        gnt0 = pick_s && (pick_id_s == M0);
        gnt1 = pick_s && (pick_id_s == M1);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM; reads return one cycle after grant.
// Define RAM_ARB_STATS_EN to add the stat_gnt0/stat_gnt1/stat_conflict counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic [DW/8-1:0]   m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,
    input  logic              m1_req,
    input  logic [DW/8-1:0]   m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,
    output logic [AW-1:0]     ram_addr,
    output logic [DW/8-1:0]   ram_wea,
    output logic [DW-1:0]     ram_dina,
    input  logic [DW-1:0]     ram_douta
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_conflict
`endif
);

    arb_state_t         state_r;
    arb_state_t         next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   next_cnt_s;
    logic               last_r;
    logic               next_last_s;
    logic               pick_gnt0_s;
    logic               pick_gnt1_s;
    logic [AW-1:0]      addr_r;
    logic [DW-1:0]      dina_r;
    logic               rd_pend_r;
    logic               rd_id_r;
    logic [DW-1:0]      rdata0_r;
    logic [DW-1:0]      rdata1_r;

    ram_arb_rr_pick #(.HOLD_MAX(HOLD_MAX)) u_pick (
        .state      (state_r),
        .req0       (m0_req),
        .req1       (m1_req),
        .cnt        (cnt_r),
        .last_owner (last_r),
        .gnt0       (pick_gnt0_s),
        .gnt1       (pick_gnt1_s),
        .next_state (next_state_s),
        .next_cnt   (next_cnt_s),
        .next_last  (next_last_s)
    );

    // Grants are suppressed while reset is held so no RAM write can leak out.
    assign m0_gnt = pick_gnt0_s & rstn;
    assign m1_gnt = pick_gnt1_s & rstn;

    assign m0_rvalid = rd_pend_r && (rd_id_r == M0);
    assign m1_rvalid = rd_pend_r && (rd_id_r == M1);
    assign m0_rdata  = m0_rvalid ? ram_douta : rdata0_r;
    assign m1_rdata  = m1_rvalid ? ram_douta : rdata1_r;

    // RAM port mux: granted master drives, otherwise hold address/data and write nothing.
    always_comb begin
        ram_addr = addr_r;
        ram_wea  = '0;
        ram_dina = dina_r;
        if (m0_gnt) begin
            ram_addr = m0_addr;
            ram_wea  = m0_we;
            ram_dina = m0_wdata;
        end else if (m1_gnt) begin
            ram_addr = m1_addr;
            ram_wea  = m1_we;
            ram_dina = m1_wdata;
        end else begin
            ram_wea  = '0;
        end
    end

    // Arbitration state, held RAM port values and read-return tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            last_r    <= M1;
            addr_r    <= '0;
            dina_r    <= '0;
            rd_pend_r <= 1'b0;
            rd_id_r   <= M0;
            rdata0_r  <= '0;
            rdata1_r  <= '0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= next_cnt_s;
            last_r    <= next_last_s;
            if (m0_gnt || m1_gnt) begin
                addr_r <= ram_addr;
                dina_r <= ram_dina;
            end
            rd_pend_r <= (m0_gnt && (m0_we == '0)) || (m1_gnt && (m1_we == '0));
            rd_id_r   <= m1_gnt ? M1 : M0;
            if (m0_rvalid) begin
                rdata0_r <= ram_douta;
            end
            if (m1_rvalid) begin
                rdata1_r <= ram_douta;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    // Free-running grant and conflict counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_gnt0     <= 32'd0;
            stat_gnt1     <= 32'd0;
            stat_conflict <= 32'd0;
        end else begin
            if (m0_gnt) begin
                stat_gnt0 <= stat_gnt0 + 32'd1;
            end
            if (m1_gnt) begin
                stat_gnt1 <= stat_gnt1 + 32'd1;
            end
            if (m0_req && m1_req) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule
